// File: rtl/unreg_deser.sv
// Serial-to-parallel receiver for the lgsynth91 shift chain.
// MSB-first capture, one-word holding buffer, sticky overrun.
module unreg_deser #(
  parameter int WIDTH  = 16,
  parameter bit INVERT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sen,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad
      $error("unreg_deser: WIDTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic             b;
  logic             done;
  logic             pop;
  logic             drop;
  logic             take;

  assign b    = sin ^ INVERT;
  assign word = {sr[WIDTH-2:0], b};

  // A bit arriving with sync opens a new word, so it never completes one.
  assign done = sen && !sync && (cnt == LAST);
  assign pop  = dvalid && dready;
  assign drop = done && dvalid && !dready;
  assign take = done && !drop;

  always_comb begin
    cnt_nx = cnt;
    if (sync) begin
      cnt_nx = CW'(sen);
    end else if (sen) begin
      if (cnt == LAST) begin
        cnt_nx = '0;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      if (sen) begin
        sr <= word;
      end
      cnt  <= cnt_nx;
      busy <= (cnt_nx != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      dvalid <= 1'b0;
    end else begin
      if (take) begin
        dout   <= word;
        dvalid <= 1'b1;
      end else if (pop) begin
        dvalid <= 1'b0;
      end
    end
  end

  // Set wins over clear when both land in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unreg_deser.sv
// Bench for unreg_deser: word-level model, scoreboard queue,
// two instances sharing stimulus (INVERT=0 and INVERT=1).
module tb_unreg_deser;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sin, sen, sync, dready, ovf_clr;
  logic [W-1:0] dout0, dout1;
  logic         dvalid0, dvalid1;
  logic         ovf0, ovf1;
  logic         busy0, busy1;

  int n_cmp  = 0;
  int n_fail = 0;

  // word-level model
  bit           bits[$];
  bit   [W-1:0] exp_q[$];
  bit           m_valid;
  bit           m_ovf;

  always #5 clk = ~clk;

  unreg_deser #(.WIDTH(W), .INVERT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sen(sen),
    .sync(sync), .dout(dout0), .dvalid(dvalid0),
    .dready(dready), .ovf(ovf0), .ovf_clr(ovf_clr),
    .busy(busy0)
  );

  unreg_deser #(.WIDTH(W), .INVERT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sen(sen),
    .sync(sync), .dout(dout1), .dvalid(dvalid1),
    .dready(dready), .ovf(ovf1), .ovf_clr(ovf_clr),
    .busy(busy1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit [W-1:0] pack_bits();
    bit [W-1:0] w = '0;
    foreach (bits[i]) w = {w[W-2:0], bits[i]};
    return w;
  endfunction

  task automatic model_step(input bit s_en, s_in, s_sync,
                            input bit rdy, clr);
    bit         complete = 1'b0;
    bit         over;
    bit [W-1:0] w = '0;
    if (s_sync) bits.delete();
    if (s_en) begin
      bits.push_back(s_in);
      if (bits.size() == W) begin
        complete = 1'b1;
        w = pack_bits();
        bits.delete();
      end
    end
    over = complete && m_valid && !rdy;
    if (complete && !over) begin
      exp_q.push_back(w);
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (over) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic cyc(input bit s_en, s_in, s_sync,
                     input bit rdy, clr);
    @(negedge clk);
    chk("dvalid", {31'd0, dvalid0}, {31'd0, m_valid});
    chk("dvalid_inv", {31'd0, dvalid1}, {31'd0, m_valid});
    chk("ovf", {31'd0, ovf0}, {31'd0, m_ovf});
    chk("ovf_inv", {31'd0, ovf1}, {31'd0, m_ovf});
    chk("busy", {31'd0, busy0}, {31'd0, bits.size() != 0});
    chk("busy_inv", {31'd0, busy1}, {31'd0, bits.size() != 0});
    sen     = s_en;
    sin     = s_in;
    sync    = s_sync;
    dready  = rdy;
    ovf_clr = clr;
    model_step(s_en, s_in, s_sync, rdy, clr);
  endtask

  task automatic send_word(input logic [W-1:0] w,
                           input bit rdy, rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      cyc(1'b1, w[i], 1'b0, (i == 0) ? rdy_last : rdy, 1'b0);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic async_rst();
    @(negedge clk);
    sen = 1'b0; sin = 1'b0; sync = 1'b0;
    dready = 1'b0; ovf_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dvalid", {31'd0, dvalid0}, 32'd0);
    chk("rst_dout", {16'd0, dout0}, 32'd0);
    chk("rst_dout_inv", {16'd0, dout1}, 32'd0);
    chk("rst_ovf", {31'd0, ovf0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    bits.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // scoreboard monitor: compare on every handshake
  initial begin : monitor
    bit [W-1:0] w;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && dvalid0 && dready) begin
        if (exp_q.size() == 0) begin
          chk("pop_empty", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk("dout", {16'd0, dout0}, {16'd0, w});
          chk("dout_inv", {16'd0, dout1}, {16'd0, ~w});
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    sen = 1'b0; sin = 1'b0; sync = 1'b0;
    dready = 1'b0; ovf_clr = 1'b0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_dout", {16'd0, dout0}, 32'd0);
    chk("init_dvalid", {31'd0, dvalid0}, 32'd0);
    #1 rst_n = 1'b1;

    send_word(16'hA5C3, 1'b1, 1'b1);
    idle(2, 1'b1);

    send_word(16'h0000, 1'b1, 1'b1);
    idle(1, 1'b1);
    send_word(16'h5A5A, 1'b1, 1'b1);
    idle(2, 1'b1);

    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'h5678, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    send_word(16'h00FF, 1'b0, 1'b0);
    send_word(16'hFF00, 1'b0, 1'b1);
    idle(3, 1'b1);

    for (int i = 0; i < 5; i++) cyc(1'b1, i[0], 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 14; i >= 0; i--) cyc(1'b1, i == 0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    send_word(16'hC0DE, 1'b0, 1'b0);
    send_word(16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    async_rst();
    send_word(16'hBEEF, 1'b1, 1'b1);
    idle(2, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) < 75,
          1'($urandom),
          $urandom_range(99) < 2,
          $urandom_range(99) < 55,
          $urandom_range(99) < 5);
    end

    idle(4, 1'b1);
    @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
